mc_ctrl_hs: RTL
===============

# mc_ctrl_hs

Next-generation multicycle control unit for the RV64I datapath. It replaces the fixed-latency state machine with one that waits on request/acknowledge handshakes for the instruction and data memories, and aborts on a configurable bus timeout. It decodes R-type, I-type ALU, load, store, BEQ/BNE and EBREAK, and raises a sticky illegal-instruction or timeout exception. It sits between the instruction register and the datapath: it drives the PC, IR, ALUOut, MDR, register-file write enables, the mux selects and the ALU operation.

## Interface
- TIMEOUT_CYC, 16: maximum request cycles (>=1) before a bus timeout.
- TIMEOUT_EN, 1: 0 disables the timeout, so a request waits indefinitely.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- INSTR  in  32  IR contents (opcode [6:0], funct3 [14:12], funct7 [31:25]).
- ALU_EQ  in  1  ALU equality flag (A==B).
- IMEM_ACK / DMEM_ACK  in  1  memory acknowledge; ignored when no request is pending.
- IMEM_REQ  out  1  instruction fetch request.
- DMEM_REQ, DMEM_WE  out  1  data request; DMEM_WE=1 for store.
- LOAD_IR, WR_OLD_PC, WRITE_PC, WR_ALU_OUT, WR_MDR, WR_BANCO_REG  out  1  register write enables.
- PC_SRC  out  1  PC input: 0 = ALU, 1 = ALUOut.
- SELETOR_MUX_A  out  2  00 PC, 01 reg A, 10 OLD_PC.
- SELETOR_MUX_B  out  2  00 reg B, 01 constant 4, 10 imm, 11 imm<<1.
- SELECT_MUX_DATA  out  1  0 ALUOut, 1 MDR.
- OPERACAO  out  3  001 add, 010 sub, 011 and, 100 xor, 101 or.
- HALTED, EXC  out  1  sticky status flags.
- EXC_CAUSE  out  2  01 illegal instruction, 10 bus timeout.

## Operation
- States: RESET, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, LD_REQ, LD_WB, ST_REQ, BRANCH, HALT, EXC.
- Unlisted outputs are 0 in every state.
- RESET: all outputs 0. Moves to FETCH on the first edge after RST deasserts.
- FETCH:
  - IMEM_REQ=1, mux A=PC, mux B=4, add.
  - LOAD_IR, WR_OLD_PC and WRITE_PC (PC_SRC=0) are combinational on IMEM_ACK (Mealy); they are asserted only in the ack cycle.
  - On ack -> DECODE.
- DECODE: mux A=OLD_PC, mux B=imm<<1, add, WR_ALU_OUT=1 (branch target). Dispatch:
  - 0110011 -> EXEC_R.
  - 0010011 -> EXEC_I.
  - 0000011 and 0100011 -> MEM_ADDR.
  - 1100011 -> BRANCH.
  - INSTR==0x00100073 -> HALT.
  - Anything else -> EXC, cause 01.
- EXEC_R:
  - Mux A=A, mux B=B, WR_ALU_OUT.
  - Op from {funct7,funct3}: 0000000/000 add, 0100000/000 sub, 0000000/111 and, 0000000/100 xor, 0000000/110 or.
  - Other codes -> EXC (01) with no writes; valid codes -> WB_ALU.
- EXEC_I: same as EXEC_R with mux B=imm; funct3 000/111/100/110 select add/and/xor/or; others -> EXC (01).
- WB_ALU: WR_BANCO_REG=1, SELECT_MUX_DATA=0 -> FETCH.
- MEM_ADDR: mux A=A, mux B=imm, add, WR_ALU_OUT. Load -> LD_REQ, store -> ST_REQ.
- LD_REQ: DMEM_REQ=1; WR_MDR is Mealy on DMEM_ACK; on ack -> LD_WB.
- LD_WB: WR_BANCO_REG=1, SELECT_MUX_DATA=1 -> FETCH.
- ST_REQ: DMEM_REQ=DMEM_WE=1; on ack -> FETCH.
- BRANCH:
  - Mux A=A, mux B=B, sub.
  - funct3 000 is taken iff ALU_EQ; funct3 001 is taken iff !ALU_EQ.
  - Taken: WRITE_PC=1, PC_SRC=1.
  - Other funct3 -> EXC (01). Otherwise -> FETCH.
- HALT / EXC: terminal until RST. All enables and requests are 0; HALTED=1 or EXC=1 with EXC_CAUSE held.
- Timeout:
  - A counter clears on entry to FETCH, LD_REQ or ST_REQ and increments on each request cycle without ack.
  - An ack in any of request cycles 1..TIMEOUT_CYC completes normally.
  - With no ack by the end of cycle TIMEOUT_CYC, the FSM enters EXC (cause 10) and the request drops.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- An ack arriving while not requesting has no effect.

## Timing
- Zero-wait latencies (ack in the first request cycle): R/I-type 4 cycles, load 5, store 4, branch 3.
- Each wait cycle adds 1 cycle.
- Status flags are registered: EXC/HALTED rise on the edge that enters EXC/HALT.
- RST asserted mid-instruction forces RESET and clears all outputs and flags immediately (asynchronous), including any pending request.

## Test plan
- Reset, then R-type add (0x002081B3) with ack in the first cycle -> IMEM_REQ in cycle 1, WR_BANCO_REG in cycle 4, OPERACAO=001 in EXEC_R, back in FETCH in cycle 5.
- Load with DMEM_ACK delayed 3 cycles -> DMEM_REQ held 4 cycles, WR_MDR pulses only in the ack cycle, SELECT_MUX_DATA=1 in LD_WB, total 8 cycles.
- BEQ with ALU_EQ=1, then BNE with ALU_EQ=1 -> first: WRITE_PC=1, PC_SRC=1 in BRANCH; second: WRITE_PC=0 in BRANCH.
- TIMEOUT_CYC=4 with IMEM_ACK never asserted -> IMEM_REQ high exactly 4 cycles, then EXC=1, EXC_CAUSE=10, all outputs 0.
- Opcode 0x7F, then R-type funct7=0000001 after reset -> EXC_CAUSE=01 both times, WR_BANCO_REG never asserted.
- EBREAK 0x00100073 -> HALTED=1 after DECODE, further acks ignored; RST pulse mid-LD_REQ -> DMEM_REQ=0 immediately, FETCH on the first edge after release.

Source files
------------

// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multicycle RV64I control FSM; memory accesses complete on req/ack handshakes.
// Latency R/I 4, load 5, store 4, branch 3 (+1 per wait cycle); a stalled request aborts after TIMEOUT_CYC cycles.
module mc_ctrl_hs #(
  parameter int TIMEOUT_CYC = 16,
  parameter bit TIMEOUT_EN  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTR,
  input  logic        ALU_EQ,
  input  logic        IMEM_ACK,
  input  logic        DMEM_ACK,
  output logic        IMEM_REQ,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic        LOAD_IR,
  output logic        WR_OLD_PC,
  output logic        WRITE_PC,
  output logic        WR_ALU_OUT,
  output logic        WR_MDR,
  output logic        WR_BANCO_REG,
  output logic        PC_SRC,
  output logic [1:0]  SELETOR_MUX_A,
  output logic [1:0]  SELETOR_MUX_B,
  output logic        SELECT_MUX_DATA,
  output logic [2:0]  OPERACAO,
  output logic        HALTED,
  output logic        EXC,
  output logic [1:0]  EXC_CAUSE
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [6:0]  OPC_R      = 7'b0110011;
  localparam logic [6:0]  OPC_I      = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] EBREAK     = 32'h0010_0073;
  localparam logic [2:0]  F3_BEQ     = 3'b000;
  localparam logic [2:0]  F3_BNE     = 3'b001;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;

  localparam logic [1:0] MUXA_PC     = 2'b00;
  localparam logic [1:0] MUXA_REG    = 2'b01;
  localparam logic [1:0] MUXA_OLDPC  = 2'b10;
  localparam logic [1:0] MUXB_REG    = 2'b00;
  localparam logic [1:0] MUXB_FOUR   = 2'b01;
  localparam logic [1:0] MUXB_IMM    = 2'b10;
  localparam logic [1:0] MUXB_IMMSH  = 2'b11;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TMO = 2'b10;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_MEM_ADDR,
    S_LD_REQ,
    S_LD_WB,
    S_ST_REQ,
    S_BRANCH,
    S_HALT,
    S_EXC
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tmo_cnt;
  logic [1:0]    exc_cause_q, cause_nxt;
  logic          tmo_hit, req_wait;
  logic [2:0]    r_op, i_op;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = INSTR[6:0];
  assign funct3 = INSTR[14:12];
  assign funct7 = INSTR[31:25];

  always_comb begin
    r_op = OP_NONE;
    case ({funct7, funct3})
      {7'b0000000, 3'b000}: r_op = OP_ADD;
      {7'b0100000, 3'b000}: r_op = OP_SUB;
      {7'b0000000, 3'b111}: r_op = OP_AND;
      {7'b0000000, 3'b100}: r_op = OP_XOR;
      {7'b0000000, 3'b110}: r_op = OP_OR;
      default:              r_op = OP_NONE;
    endcase
  end

  always_comb begin
    i_op = OP_NONE;
    case (funct3)
      3'b000:  i_op = OP_ADD;
      3'b111:  i_op = OP_AND;
      3'b100:  i_op = OP_XOR;
      3'b110:  i_op = OP_OR;
      default: i_op = OP_NONE;
    endcase
  end

  // tmo_cnt holds the number of already-elapsed unacknowledged request cycles
  assign tmo_hit  = TIMEOUT_EN && (tmo_cnt == TMO_LAST);
  assign req_wait = (IMEM_REQ && !IMEM_ACK) || (DMEM_REQ && !DMEM_ACK);

  always_comb begin
    state_nxt       = state;
    cause_nxt       = exc_cause_q;
    IMEM_REQ        = 1'b0;
    DMEM_REQ        = 1'b0;
    DMEM_WE         = 1'b0;
    LOAD_IR         = 1'b0;
    WR_OLD_PC       = 1'b0;
    WRITE_PC        = 1'b0;
    WR_ALU_OUT      = 1'b0;
    WR_MDR          = 1'b0;
    WR_BANCO_REG    = 1'b0;
    PC_SRC          = 1'b0;
    SELETOR_MUX_A   = MUXA_PC;
    SELETOR_MUX_B   = MUXB_REG;
    SELECT_MUX_DATA = 1'b0;
    OPERACAO        = OP_NONE;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        IMEM_REQ      = 1'b1;
        SELETOR_MUX_A = MUXA_PC;
        SELETOR_MUX_B = MUXB_FOUR;
        OPERACAO      = OP_ADD;
        if (IMEM_ACK) begin
          LOAD_IR   = 1'b1;
          WR_OLD_PC = 1'b1;
          WRITE_PC  = 1'b1;
          state_nxt = S_DECODE;
        end else if (tmo_hit) begin
          state_nxt = S_EXC;
          cause_nxt = CAUSE_TMO;
        end
      end
      S_DECODE: begin
        // branch target is precomputed here so BRANCH only needs the compare
        SELETOR_MUX_A = MUXA_OLDPC;
        SELETOR_MUX_B = MUXB_IMMSH;
        OPERACAO      = OP_ADD;
        WR_ALU_OUT    = 1'b1;
        if (INSTR == EBREAK) begin
          state_nxt = S_HALT;
        end else begin
          case (opcode)
            OPC_R:                state_nxt = S_EXEC_R;
            OPC_I:                state_nxt = S_EXEC_I;
            OPC_LOAD, OPC_STORE:  state_nxt = S_MEM_ADDR;
            OPC_BRANCH:           state_nxt = S_BRANCH;
            default: begin
              state_nxt = S_EXC;
              cause_nxt = CAUSE_ILL;
            end
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        SELETOR_MUX_A = MUXA_REG;
        SELETOR_MUX_B = (state == S_EXEC_R) ? MUXB_REG : MUXB_IMM;
        OPERACAO      = (state == S_EXEC_R) ? r_op : i_op;
        if (OPERACAO != OP_NONE) begin
          WR_ALU_OUT = 1'b1;
          state_nxt  = S_WB_ALU;
        end else begin
          state_nxt = S_EXC;
          cause_nxt = CAUSE_ILL;
        end
      end
      S_WB_ALU: begin
        WR_BANCO_REG    = 1'b1;
        SELECT_MUX_DATA = 1'b0;
        state_nxt       = S_FETCH;
      end
      S_MEM_ADDR: begin
        SELETOR_MUX_A = MUXA_REG;
        SELETOR_MUX_B = MUXB_IMM;
        OPERACAO      = OP_ADD;
        WR_ALU_OUT    = 1'b1;
        state_nxt     = (opcode == OPC_LOAD) ? S_LD_REQ : S_ST_REQ;
      end
      S_LD_REQ: begin
        DMEM_REQ = 1'b1;
        if (DMEM_ACK) begin
          WR_MDR    = 1'b1;
          state_nxt = S_LD_WB;
        end else if (tmo_hit) begin
          state_nxt = S_EXC;
          cause_nxt = CAUSE_TMO;
        end
      end
      S_LD_WB: begin
        WR_BANCO_REG    = 1'b1;
        SELECT_MUX_DATA = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_ST_REQ: begin
        DMEM_REQ = 1'b1;
        DMEM_WE  = 1'b1;
        if (DMEM_ACK) begin
          state_nxt = S_FETCH;
        end else if (tmo_hit) begin
          state_nxt = S_EXC;
          cause_nxt = CAUSE_TMO;
        end
      end
      S_BRANCH: begin
        SELETOR_MUX_A = MUXA_REG;
        SELETOR_MUX_B = MUXB_REG;
        OPERACAO      = OP_SUB;
        state_nxt     = S_FETCH;
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          if (ALU_EQ == (funct3 == F3_BEQ)) begin
            WRITE_PC = 1'b1;
            PC_SRC   = 1'b1;
          end
        end else begin
          state_nxt = S_EXC;
          cause_nxt = CAUSE_ILL;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      S_EXC:   state_nxt = S_EXC;
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_RESET;
      tmo_cnt     <= '0;
      exc_cause_q <= '0;
    end else begin
      state       <= state_nxt;
      exc_cause_q <= cause_nxt;
      if (state_nxt != state) begin
        tmo_cnt <= '0;
      end else if (req_wait && TIMEOUT_EN) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
    end
  end

  assign HALTED    = (state == S_HALT);
  assign EXC       = (state == S_EXC);
  assign EXC_CAUSE = exc_cause_q;

endmodule
